// File: rtl/pipe_scoreboard_if.sv
// ID-stage issue/hazard bundle between the decode stage (master) and the scoreboard (slave).
// Widths follow the scoreboard parameters AW, RW and SELW.
interface pipe_scoreboard_if #(
    parameter int AW   = 5,
    parameter int RW   = 2,
    parameter int SELW = 2
);
    logic            hold_i;
    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_we_i;
    logic [AW-1:0]   issue_rd_i;
    logic [RW-1:0]   issue_rdy_i;
    logic            use_a_i;
    logic            use_b_i;
    logic [AW-1:0]   src_a_i;
    logic [AW-1:0]   src_b_i;
    logic            stall_o;
    logic [SELW-1:0] fwd_a_o;
    logic [SELW-1:0] fwd_b_o;
    logic            busy_o;
    logic [31:0]     stall_cnt_o;
    logic [31:0]     flush_cnt_o;

    modport master (
        output hold_i, flush_i, issue_valid_i, issue_we_i, issue_rd_i, issue_rdy_i,
        output use_a_i, use_b_i, src_a_i, src_b_i,
        input  stall_o, fwd_a_o, fwd_b_o, busy_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  hold_i, flush_i, issue_valid_i, issue_we_i, issue_rd_i, issue_rdy_i,
        input  use_a_i, use_b_i, src_a_i, src_b_i,
        output stall_o, fwd_a_o, fwd_b_o, busy_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Hazard-interlock and forwarding-select scoreboard for the in-order pipeline (EX..WB window).
// Optional stall/flush performance counters are built when SB_PERF_CNT_EN is defined.

module pipe_scoreboard_chk #(
    parameter int NSTAGE = 3,
    parameter int RW     = 2,
    parameter int SELW   = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          issue_valid_i,
    input logic          flush_i,
    input logic [RW-1:0] issue_rdy_i
);
    if (NSTAGE < 2 || NSTAGE > 8) begin : g_bad_nstage
        $error("pipe_scoreboard: NSTAGE out of range 2..8");
    end
    if ((1 << SELW) < NSTAGE) begin : g_bad_selw
        $error("pipe_scoreboard: SELW too narrow for NSTAGE");
    end
    if ((1 << RW) < NSTAGE) begin : g_bad_rw
        $error("pipe_scoreboard: RW too narrow for NSTAGE");
    end

    // A result must become available inside the tracked window.
    rdy_in_range_a: assert property (@(posedge clk) disable iff (rst)
        (issue_valid_i && !flush_i) |-> (int'(issue_rdy_i) < NSTAGE));
endmodule

module pipe_scoreboard #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int SELW   = 2,
    parameter int RW     = 2
) (
    input logic              clk,
    input logic              rst,
    pipe_scoreboard_if.slave sb
);
    typedef struct packed {
        logic            haz;
        logic [SELW-1:0] sel;
    } look_t;

    logic [NSTAGE-1:0] v_q, v_d;
    logic [NSTAGE-1:0] we_q, we_d;
    logic [AW-1:0]     rd_q  [NSTAGE];
    logic [AW-1:0]     rd_d  [NSTAGE];
    logic [RW-1:0]     rdy_q [NSTAGE];
    logic [RW-1:0]     rdy_d [NSTAGE];
    logic [SELW-1:0]   fwd_a_q, fwd_a_d;
    logic [SELW-1:0]   fwd_b_q, fwd_b_d;
    logic              busy_q, busy_d;
    look_t             look_a_s, look_b_s;
    logic              stall_s;
    logic              accept_s;

    // Scan oldest to youngest so the youngest matching producer overrides older ones.
    function automatic look_t lookup(input logic use_s, input logic [AW-1:0] src);
        look_t res;
        look_t cand;
        logic  hit;
        res = '0;
        for (int j = NSTAGE - 1; j >= 0; j--) begin
            hit      = use_s && (src != {AW{1'b0}}) && v_q[j] && we_q[j] && (rd_q[j] == src);
            cand.haz = int'(rdy_q[j]) > j;
            cand.sel = (!cand.haz && (j <= NSTAGE - 2)) ? SELW'(j + 1) : {SELW{1'b0}};
            res      = hit ? cand : res;
        end
        return res;
    endfunction

    // Source lookup and interlock decision for the instruction sitting in ID.
    always_comb begin
        look_a_s = lookup(sb.use_a_i, sb.src_a_i);
        look_b_s = lookup(sb.use_b_i, sb.src_b_i);
        stall_s  = sb.issue_valid_i && !sb.flush_i && (look_a_s.haz || look_b_s.haz);
        accept_s = sb.issue_valid_i && !sb.flush_i && !stall_s;
    end

    // Advance the in-flight window and load ID into EX unless the pipeline is frozen.
    always_comb begin
        v_d     = v_q;
        we_d    = we_q;
        rd_d    = rd_q;
        rdy_d   = rdy_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (sb.hold_i) begin
            v_d = v_q;
        end else begin
            for (int j = 1; j < NSTAGE; j++) begin
                v_d[j]   = v_q[j-1];
                we_d[j]  = we_q[j-1];
                rd_d[j]  = rd_q[j-1];
                rdy_d[j] = rdy_q[j-1];
            end
            v_d[0]   = accept_s;
            we_d[0]  = sb.issue_we_i;
            rd_d[0]  = sb.issue_rd_i;
            rdy_d[0] = sb.issue_rdy_i;
            fwd_a_d  = accept_s ? look_a_s.sel : {SELW{1'b0}};
            fwd_b_d  = accept_s ? look_b_s.sel : {SELW{1'b0}};
        end
        busy_d = |v_d;
    end

    // Scoreboard state and registered forwarding selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= {NSTAGE{1'b0}};
            we_q    <= {NSTAGE{1'b0}};
            fwd_a_q <= {SELW{1'b0}};
            fwd_b_q <= {SELW{1'b0}};
            busy_q  <= 1'b0;
            for (int j = 0; j < NSTAGE; j++) begin
                rd_q[j]  <= {AW{1'b0}};
                rdy_q[j] <= {RW{1'b0}};
            end
        end else begin
            v_q     <= v_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            busy_q  <= busy_d;
        end
    end

    assign sb.stall_o = stall_s;
    assign sb.fwd_a_o = fwd_a_q;
    assign sb.fwd_b_o = fwd_b_q;
    assign sb.busy_o  = busy_q;

`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; frozen cycles are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!sb.hold_i && stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!sb.hold_i && sb.flush_i && sb.issue_valid_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign sb.stall_cnt_o = stall_cnt_q;
    assign sb.flush_cnt_o = flush_cnt_q;
`else
    assign sb.stall_cnt_o = 32'd0;
    assign sb.flush_cnt_o = 32'd0;
`endif

    pipe_scoreboard_chk #(
        .NSTAGE (NSTAGE),
        .RW     (RW),
        .SELW   (SELW)
    ) u_chk (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (sb.issue_valid_i),
        .flush_i       (sb.flush_i),
        .issue_rdy_i   (sb.issue_rdy_i)
    );
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard-interlock and forwarding-select unit for the in-order integer pipeline.
- Tracks every in-flight instruction from EX to WB in a shift register of destination/ready-stage entries.
- Compares the ID-stage source registers against those entries and produces a combinational stall request plus registered EX-stage forwarding selects.
- Replaces fixed 5-stage hazard/forward logic; supports any post-ID depth and per-instruction result latency (ALU, load, multi-cycle).

Parameters:
- NSTAGE, 3, number of post-ID stages tracked; stage 0 = EX, stage NSTAGE-1 = WB. Legal range 2..8.
- AW, 5, register address width.
- SELW, 2, forwarding select width; must satisfy 2^SELW >= NSTAGE.
- RW, 2, ready-stage field width; must satisfy 2^RW >= NSTAGE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- hold_i  in  1  global freeze (I/D cache stall).
- flush_i  in  1  branch taken: the ID instruction is killed.
- issue_valid_i  in  1  ID holds a real instruction.
- issue_we_i  in  1  ID instruction writes a register.
- issue_rd_i  in  AW  ID destination register.
- issue_rdy_i  in  RW  stage index at whose end the result exists (0 = ALU, 1 = load).
- use_a_i, use_b_i  in  1 each  ID reads rs / rt.
- src_a_i, src_b_i  in  AW each  ID rs / rt addresses.
- stall_o  out  1  combinational; ID must hold and a bubble enters EX.
- fwd_a_o, fwd_b_o  out  SELW each  registered EX operand source: 0 = register-file data, k = pipeline register of stage k.
- busy_o  out  1  any valid entry in flight.
- stall_cnt_o, flush_cnt_o  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Each entry e[j], j = 0..NSTAGE-1, holds {v, we, rd, rdy}. Reset (async, rst high) clears all fields. Reset values: fwd_a_o = fwd_b_o = 0, busy_o = 0, counters = 0.
- Live match for source s at stage j: e[j].v && e[j].we && e[j].rd == s && s != 0 && use_s. Register 0 never matches.
- The youngest match (smallest j) wins. Older matches are ignored.
- Hazard for source s: youngest match j has e[j].rdy > j.
- stall_o = issue_valid_i && !flush_i && (hazard_a || hazard_b). It is independent of hold_i.
- Forward select for source s:
  - j+1 if the youngest match has j <= NSTAGE-2 and no hazard;
  - 0 if there is no match, or the match is at stage NSTAGE-1. The RF is write-through, so a WB write is visible to the same-cycle ID read.
- Per-edge update, in priority order:
  - rst: clear everything.
  - hold_i: all entries and fwd outputs keep their values.
  - otherwise: e[j+1] <= e[j] for j < NSTAGE-1, and e[NSTAGE-1] retires.
  - e[0] <= bubble (v = 0) if flush_i, stall_o, or !issue_valid_i; else e[0] <= {1, issue_we_i, issue_rd_i, issue_rdy_i}.
  - fwd_a_o / fwd_b_o <= computed selects when e[0] gets a valid instruction, else 0.
- Forwarding and stall latency: matches are computed in ID, selects are used in EX exactly one un-held cycle later. A stall lasts until the producer reaches stage rdy.
- A load (rdy = 1) consumed immediately costs exactly 1 stall cycle. An entry with rdy = r consumed immediately costs r cycles.
- Simultaneous events:
  - flush_i and a hazard together: flush wins; stall_o = 0 and a bubble is inserted.
  - hold_i and stall_o together: nothing moves; stall_o stays asserted.
- issue_rdy_i >= NSTAGE is illegal; behaviour is undefined and an assertion fires in simulation.
- busy_o = OR of all e[j].v (registered-state derived, no input path).
- Reset mid-stream: all in-flight entries are dropped immediately. The first post-reset issue sees no hazards.

Optional Feature:
- Macro SB_PERF_CNT_EN.
- When defined:
  - stall_cnt_o increments on each non-held edge where stall_o = 1.
  - flush_cnt_o increments on each non-held edge where flush_i && issue_valid_i.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- When undefined: both outputs are tied to 0 and no flops are inferred.

Test Plan:
- Back-to-back ALU dependency. Issue add r3 (rdy 0), then sub r4 <- r3, r5. Required: stall_o = 0; next cycle fwd_a_o = 1, fwd_b_o = 0.
- Load-use. Issue lw r8 (rdy 1), then add r9 <- r8, r8. Required: stall_o = 1 for exactly 1 cycle; after it, fwd_a_o = fwd_b_o = 2; the EX entry is a bubble.
- Two-apart and WB write-through. r3 producer, two independent instructions, then consumer of r3. Required: fwd = 0, stall_o = 0.
- r0, youngest-wins and hold. Producer of r0 followed by consumer of r0: fwd = 0. Two producers of r7 then a consumer: fwd = 1. Assert hold_i 3 cycles mid-hazard: entries, fwd and stall_o frozen.
- Flush over hazard. lw r8 then consumer with flush_i = 1 in the same cycle. Required: stall_o = 0, bubble inserted, flush_cnt_o = 1 with SB_PERF_CNT_EN.
- NSTAGE = 5. Entry with rdy = 3 consumed immediately. Required: 3 stall cycles, then fwd = 4. Async rst mid-stall: busy_o = 0 and stall_o = 0 immediately.
